pipe_reg: RTL and testbench

//   Parametrised DEPTH-stage pipeline register with valid/ready handshake, per-stage valid bits,

---
 rtl/dp_pkg.sv | 23 ++
 rtl/pipe_stage.sv | 42 ++++
 rtl/pipe_reg.sv | 113 +++++++++++
 tb/tb_pipe_reg.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// rtl/dp_pkg.sv - shared datapath helpers: clog2 and parameter legality checks
package dp_pkg;

    localparam int DP_MIN_WIDTH = 1;
    localparam int DP_MIN_DEPTH = 1;

    function automatic int clog2(input int n);
        int r;
        int m;
        r = 0;
        m = n - 1;
        while (m > 0) begin
            r = r + 1;
            m = m >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic bit cfg_ok(input int width, input int depth);
        return (width >= DP_MIN_WIDTH) && (depth >= DP_MIN_DEPTH);
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - one pipeline stage: valid bit, data reg, optional parity bit (PIPE_REG_PARITY_EN)
module pipe_stage #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             flush,
    input  logic             load,
    input  logic             v_in,
    input  logic [WIDTH-1:0] d_in,
`ifdef PIPE_REG_PARITY_EN
    input  logic             par_in,
    output logic             par,
`endif
    output logic             v,
    output logic [WIDTH-1:0] data
);

    // Flush only drops the valid bit; data payload is left as-is.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            v    <= 1'b0;
            data <= '0;
        end else if (flush) begin
            v    <= 1'b0;
        end else if (load) begin
            v    <= v_in;
            data <= d_in;
        end
    end

`ifdef PIPE_REG_PARITY_EN
    always_ff @(posedge Clk) begin
        if (Rst) begin
            par <= 1'b0;
        end else if (!flush && load) begin
            par <= par_in;
        end
    end
`endif

endmodule

// File: rtl/pipe_reg.sv
// rtl/pipe_reg.sv - DEPTH-stage elastic pipeline register with flush and occupancy; parity option PIPE_REG_PARITY_EN
module pipe_reg
    import dp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                        Clk,
    input  logic                        Rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH-1:0]            d,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            q,
    output logic [clog2(DEPTH+1)-1:0]   occupancy
`ifdef PIPE_REG_PARITY_EN
    ,
    output logic                        parity_err
`endif
);

    localparam int OCC_W = clog2(DEPTH + 1);

    if (!cfg_ok(WIDTH, DEPTH)) begin : g_bad_cfg
        $error("pipe_reg: WIDTH and DEPTH must both be >= 1");
    end

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] data [DEPTH];
    logic             in_xfer;
    logic             out_xfer;
`ifdef PIPE_REG_PARITY_EN
    logic [DEPTH-1:0] par;
`endif

    // adv[i] is true when any stage at or after i is empty, or the sink drains this cycle.
    always_comb begin
        logic acc;
        acc = out_ready;
        adv = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            acc    = acc | ~v[i];
            adv[i] = acc;
        end
    end

    assign in_ready  = adv[0] & ~flush;
    assign in_xfer   = in_valid & in_ready;
    assign out_valid = v[DEPTH-1];
    assign q         = data[DEPTH-1];
    assign out_xfer  = out_valid & out_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             v_src;
        logic [WIDTH-1:0] d_src;
`ifdef PIPE_REG_PARITY_EN
        logic             p_src;
`endif
        if (i == 0) begin : g_head
            assign v_src = in_valid & ~flush;
            assign d_src = d;
`ifdef PIPE_REG_PARITY_EN
            assign p_src = ^d;
`endif
        end else begin : g_body
            assign v_src = v[i-1];
            assign d_src = data[i-1];
`ifdef PIPE_REG_PARITY_EN
            assign p_src = par[i-1];
`endif
        end

        pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .Clk    (Clk),
            .Rst    (Rst),
            .flush  (flush),
            .load   (adv[i]),
            .v_in   (v_src),
            .d_in   (d_src),
`ifdef PIPE_REG_PARITY_EN
            .par_in (p_src),
            .par    (par[i]),
`endif
            .v      (v[i]),
            .data   (data[i])
        );
    end

    always_ff @(posedge Clk) begin
        if (Rst || flush) begin
            occupancy <= '0;
        end else begin
            occupancy <= occupancy + OCC_W'(in_xfer) - OCC_W'(out_xfer);
        end
    end

`ifdef PIPE_REG_PARITY_EN
    // Sticky: survives flush so a corrupted word cannot be hidden by clearing the pipe.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            parity_err <= 1'b0;
        end else if (out_xfer && (^{q, par[DEPTH-1]})) begin
            parity_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_reg.sv
// tb/tb_pipe_reg.sv - directed self-checking bench for pipe_reg (DEPTH=2, WIDTH=8)
`timescale 1ns/1ps
module tb_pipe_reg;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic             Clk;
    logic             Rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] d;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] q;
    logic [1:0]       occupancy;
`ifdef PIPE_REG_PARITY_EN
    logic             parity_err;
`endif

    int checks;
    int errors;

    pipe_reg #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .d          (d),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .q          (q),
        .occupancy  (occupancy)
`ifdef PIPE_REG_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        Rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        d         = 8'hA5;
        out_ready = 1'b0;

        // Reset
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_q", 32'(q), 32'h0);
        check("rst_occ", 32'(occupancy), 32'd0);
`ifdef PIPE_REG_PARITY_EN
        check("rst_perr", 32'(parity_err), 32'd0);
`endif
        Rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Streaming: q=k-1 visible after the edge that enters k
        out_ready = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            in_valid = 1'b1;
            d        = 8'(k);
            step();
            if (k >= 2) begin
                check($sformatf("stream_q%0d", k), 32'(q), 32'(k - 1));
                check($sformatf("stream_v%0d", k), 32'(out_valid), 32'd1);
            end
            if (k == 4) check("stream_occ", 32'(occupancy), 32'd2);
        end
        in_valid = 1'b0;
        step();
        check("stream_last_q", 32'(q), 32'd6);
        step();
        check("stream_drain_v", 32'(out_valid), 32'd0);
        check("stream_drain_occ", 32'(occupancy), 32'd0);

        // Back-pressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        d         = 8'h11;
        #1;
        check("bp_rdy0", 32'(in_ready), 32'd1);
        step();
        d = 8'h22;
        step();
        check("bp_occ_full", 32'(occupancy), 32'd2);
        check("bp_q_first", 32'(q), 32'h11);
        d = 8'h33;
        #1;
        check("bp_rdy_full", 32'(in_ready), 32'd0);
        step();
        check("bp_q_held", 32'(q), 32'h11);
        check("bp_occ_held", 32'(occupancy), 32'd2);
        out_ready = 1'b1;
        #1;
        check("bp_rdy_drain", 32'(in_ready), 32'd1);
        step();
        check("bp_q2", 32'(q), 32'h22);
        check("bp_occ_swap", 32'(occupancy), 32'd2);
        in_valid = 1'b0;
        step();
        check("bp_q3", 32'(q), 32'h33);
        check("bp_occ1", 32'(occupancy), 32'd1);
        step();
        check("bp_empty_v", 32'(out_valid), 32'd0);
        check("bp_empty_occ", 32'(occupancy), 32'd0);

        // Bubble collapse
        out_ready = 1'b0;
        in_valid  = 1'b1;
        d         = 8'h44;
        step();
        in_valid = 1'b0;
        step();
        in_valid = 1'b1;
        d        = 8'h55;
        step();
        in_valid = 1'b0;
        #1;
        check("bub_occ", 32'(occupancy), 32'd2);
        check("bub_q", 32'(q), 32'h44);
        check("bub_rdy", 32'(in_ready), 32'd0);

        // Flush with full pipe draining: output transfer still happens, input refused
        out_ready = 1'b1;
        flush     = 1'b1;
        in_valid  = 1'b1;
        d         = 8'h66;
        #1;
        check("fl_rdy", 32'(in_ready), 32'd0);
        check("fl_out_v", 32'(out_valid), 32'd1);
        check("fl_out_q", 32'(q), 32'h44);
        step();
        check("fl_after_v", 32'(out_valid), 32'd0);
        check("fl_after_occ", 32'(occupancy), 32'd0);
        flush     = 1'b0;
        out_ready = 1'b0;
        d         = 8'h77;
        step();
        in_valid = 1'b0;
        step();
        check("fl_refill_q", 32'(q), 32'h77);
        check("fl_refill_occ", 32'(occupancy), 32'd1);
        Rst   = 1'b1;
        flush = 1'b1;
        step();
        check("rstfl_v", 32'(out_valid), 32'd0);
        check("rstfl_q", 32'(q), 32'h0);
        check("rstfl_occ", 32'(occupancy), 32'd0);
        Rst   = 1'b0;
        flush = 1'b0;

`ifdef PIPE_REG_PARITY_EN
        // Corrupt the word sitting in the last stage, then let it leave
        out_ready = 1'b0;
        in_valid  = 1'b1;
        d         = 8'h0F;
        step();
        in_valid = 1'b0;
        step();
        check("par_clean", 32'(parity_err), 32'd0);
        force dut.g_stage[DEPTH-1].u_stage.data = 8'h0E;
        #1;
        release dut.g_stage[DEPTH-1].u_stage.data;
        out_ready = 1'b1;
        step();
        check("par_set", 32'(parity_err), 32'd1);
        flush = 1'b1;
        step();
        check("par_sticky_flush", 32'(parity_err), 32'd1);
        flush = 1'b0;
        Rst   = 1'b1;
        step();
        check("par_rst_clear", 32'(parity_err), 32'd0);
        Rst = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
